mmcm_drp_reconfig: RTL and testbench

- Run-time reconfiguration controller for the video-clock MMCM.
- Holds the MMCM in reset, then read-modify-writes a table of DRP registers fetched from an external ROM. It then releases reset and waits for lock.
- Lets top level switch pixel/5x clock sets between up to 2^CFG_W video modes. After its own reset it also acts as the MMCM power-up reset sequencer.
- Clocked by the 12 MHz oscillator, which also drives the MMCM DCLK.

---
 rtl/mmcm_drp_reconfig_if.sv | 21 ++
 rtl/mmcm_drp_reconfig.sv | 193 +++++++++++++++++++
 tb/tb_mmcm_drp_reconfig.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmcm_drp_reconfig_if.sv
// MMCM-facing bundle: DRP port plus the reset/lock pair of the video-clock MMCM.
interface mmcm_drp_reconfig_if;
   logic [6:0]  drp_daddr;
   logic        drp_den;
   logic        drp_dwe;
   logic [15:0] drp_di;
   logic [15:0] drp_do;
   logic        drp_drdy;
   logic        mmcm_rst;
   logic        mmcm_locked;

   modport master (
      output drp_daddr, drp_den, drp_dwe, drp_di, mmcm_rst,
      input  drp_do, drp_drdy, mmcm_locked
   );

   modport slave (
      input  drp_daddr, drp_den, drp_dwe, drp_di, mmcm_rst,
      output drp_do, drp_drdy, mmcm_locked
   );
endinterface

// File: rtl/mmcm_drp_reconfig.sv
// Video-clock MMCM reconfiguration controller and power-up reset sequencer.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// RELEASE   | drop MMCM reset, load lock timer
// WAIT_LOCK | wait for synchronized lock (armed after low seen or 4 cycles)
// IDLE      | not busy, accepts cfg_req
// ROM_RD    | present {sel, idx} to the ROM
// ROM_WAIT  | ROM data valid, latch addr/mask/data
// DRP_RD    | one-cycle DRP read strobe
// WAIT_RD   | wait for read DRDY or timeout
// DRP_WR    | one-cycle DRP write strobe with merged data
// WAIT_WR   | wait for write DRDY or timeout, then next entry or RELEASE
module mmcm_drp_reconfig #(
   parameter int CFG_W        = 2,
   parameter int IDX_W        = 3,
   parameter int DRDY_TIMEOUT = 64,
   parameter int LOCK_TIMEOUT = 12000
) (
   input  logic                   clk12,
   input  logic                   rst,
   input  logic                   cfg_req,
   input  logic [CFG_W-1:0]       cfg_sel,
   output logic                   cfg_busy,
   output logic                   cfg_done,
   output logic                   cfg_err,
   output logic [CFG_W+IDX_W-1:0] rom_addr,
   input  logic [38:0]            rom_data,
   mmcm_drp_reconfig_if.master    drp
);
   localparam int TMR_MAX = (LOCK_TIMEOUT > DRDY_TIMEOUT) ? LOCK_TIMEOUT : DRDY_TIMEOUT;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam logic [TMR_W-1:0] DRDY_LD  = TMR_W'(DRDY_TIMEOUT - 1);
   localparam logic [TMR_W-1:0] LOCK_LD  = TMR_W'(LOCK_TIMEOUT - 1);
   // Timer value once four WAIT_LOCK cycles have elapsed
   localparam logic [TMR_W-1:0] LOCK_ARM = TMR_W'(LOCK_TIMEOUT - 5);

   typedef enum logic [3:0] {
      RELEASE, WAIT_LOCK, IDLE, ROM_RD, ROM_WAIT, DRP_RD, WAIT_RD, DRP_WR, WAIT_WR
   } state_t;

   state_t            state_q, state_d;
   logic [CFG_W-1:0]  sel_q;
   logic [IDX_W-1:0]  idx_q;
   logic [6:0]        addr_q;
   logic [15:0]       mask_q, data_q, do_q;
   logic [TMR_W-1:0]  tmr_q;
   logic [1:0]        lock_sync_q;
   logic              lock_s, seen_low_q, req_q, mmcm_rst_q, tmr_tc;
   logic              accept, rom_latch, do_latch, idx_inc;
   logic              ld_drdy, ld_lock, tmr_dec, drdy_err, lock_err, lock_ok;

   assign lock_s   = lock_sync_q[1];
   assign tmr_tc   = (tmr_q == '0);
   assign cfg_busy = (state_q != IDLE);
   assign rom_addr = {sel_q, idx_q};

   assign drp.drp_daddr = addr_q;
   assign drp.drp_den   = (state_q == DRP_RD) || (state_q == DRP_WR);
   assign drp.drp_dwe   = (state_q == DRP_WR);
   // Mask bit set keeps the bit read back from the MMCM
   assign drp.drp_di    = (do_q & mask_q) | (data_q & ~mask_q);
   assign drp.mmcm_rst  = mmcm_rst_q;

   // Two-flop synchronizer for the asynchronous lock indication
   always_ff @(posedge clk12) begin
      if (rst) lock_sync_q <= 2'b00;
      else     lock_sync_q <= {lock_sync_q[0], drp.mmcm_locked};
   end

   // State register; reset restarts the boot sequence
   always_ff @(posedge clk12) begin
      if (rst) state_q <= RELEASE;
      else     state_q <= state_d;
   end

   // Next-state and per-state control strobes
   always_comb begin
      state_d   = state_q;
      accept    = 1'b0;
      rom_latch = 1'b0;
      do_latch  = 1'b0;
      idx_inc   = 1'b0;
      ld_drdy   = 1'b0;
      ld_lock   = 1'b0;
      tmr_dec   = 1'b0;
      drdy_err  = 1'b0;
      lock_err  = 1'b0;
      lock_ok   = 1'b0;
      case (state_q)
         IDLE: if (cfg_req) begin
            accept  = 1'b1;
            state_d = ROM_RD;
         end
         ROM_RD:   state_d = ROM_WAIT;
         ROM_WAIT: begin
            rom_latch = 1'b1;
            state_d   = DRP_RD;
         end
         DRP_RD: begin
            ld_drdy = 1'b1;
            state_d = WAIT_RD;
         end
         WAIT_RD: begin
            if (drp.drp_drdy) begin
               do_latch = 1'b1;
               state_d  = DRP_WR;
            end else if (tmr_tc) begin
               drdy_err = 1'b1;
               state_d  = IDLE;
            end else begin
               tmr_dec = 1'b1;
            end
         end
         DRP_WR: begin
            ld_drdy = 1'b1;
            state_d = WAIT_WR;
         end
         WAIT_WR: begin
            if (drp.drp_drdy) begin
               if (idx_q == '1) begin
                  state_d = RELEASE;
               end else begin
                  idx_inc = 1'b1;
                  state_d = ROM_RD;
               end
            end else if (tmr_tc) begin
               drdy_err = 1'b1;
               state_d  = IDLE;
            end else begin
               tmr_dec = 1'b1;
            end
         end
         RELEASE: begin
            ld_lock = 1'b1;
            state_d = WAIT_LOCK;
         end
         WAIT_LOCK: begin
            if (lock_s && (seen_low_q || (tmr_q <= LOCK_ARM))) begin
               lock_ok = 1'b1;
               state_d = IDLE;
            end else if (tmr_tc) begin
               lock_err = 1'b1;
               state_d  = IDLE;
            end else begin
               tmr_dec = 1'b1;
            end
         end
         default: state_d = RELEASE;
      endcase
   end

   // Datapath registers, shared timeout down-counter and status flags
   always_ff @(posedge clk12) begin
      if (rst) begin
         sel_q      <= '0;
         idx_q      <= '0;
         addr_q     <= '0;
         mask_q     <= '0;
         data_q     <= '0;
         do_q       <= '0;
         tmr_q      <= '0;
         seen_low_q <= 1'b0;
         req_q      <= 1'b0;
         mmcm_rst_q <= 1'b1;
         cfg_err    <= 1'b0;
         cfg_done   <= 1'b0;
      end else begin
         cfg_done <= lock_ok & req_q;
         if (accept) begin
            sel_q      <= cfg_sel;
            idx_q      <= '0;
            cfg_err    <= 1'b0;
            mmcm_rst_q <= 1'b1;
            req_q      <= 1'b1;
         end
         if (idx_inc) idx_q <= idx_q + IDX_W'(1);
         if (rom_latch) begin
            addr_q <= rom_data[38:32];
            mask_q <= rom_data[31:16];
            data_q <= rom_data[15:0];
         end
         if (do_latch) do_q <= drp.drp_do;
         if (drdy_err || lock_err) cfg_err <= 1'b1;
         if (drdy_err || (state_q == RELEASE)) mmcm_rst_q <= 1'b0;
         if (ld_drdy)      tmr_q <= DRDY_LD;
         else if (ld_lock) tmr_q <= LOCK_LD;
         else if (tmr_dec) tmr_q <= tmr_q - TMR_W'(1);
         if (state_q == RELEASE)                  seen_low_q <= 1'b0;
         else if (state_q == WAIT_LOCK && !lock_s) seen_low_q <= 1'b1;
      end
   end
endmodule

// File: tb/tb_mmcm_drp_reconfig.sv
// Bench: ROM + MMCM behavioural models, reference model of the read-modify-write
// sequence, scoreboard of expected DRP accesses and request outcomes.
`timescale 1ns/1ps
module tb_mmcm_drp_reconfig;
   localparam int DRDY_TO  = 64;
   localparam int LOCK_TO  = 12000;
   localparam int LOCK_LAT = 100;

   logic        clk12 = 1'b0;
   logic        rst, cfg_req;
   logic [1:0]  cfg_sel;
   logic        cfg_busy, cfg_done, cfg_err;
   logic [4:0]  rom_addr;
   logic [38:0] rom_data;

   mmcm_drp_reconfig_if drp ();

   mmcm_drp_reconfig #(
      .CFG_W(2), .IDX_W(3), .DRDY_TIMEOUT(DRDY_TO), .LOCK_TIMEOUT(LOCK_TO)
   ) dut (
      .clk12(clk12), .rst(rst), .cfg_req(cfg_req), .cfg_sel(cfg_sel),
      .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err),
      .rom_addr(rom_addr), .rom_data(rom_data), .drp(drp.master)
   );

   always #5 clk12 = ~clk12;

   typedef struct { bit we; logic [6:0] addr; logic [15:0] di; logic [4:0] rom; } acc_t;
   typedef struct { bit done; bit err; bit lock_to; } out_t;

   acc_t        acc_q[$];
   out_t        out_q[$];
   logic [38:0] rom_mem [32];
   logic [15:0] mmcm_mem [128];
   logic [15:0] ref_mem [128];
   int          checks = 0, errors = 0;
   int          lat_fix = -1, drop_at = -1, acc_n = 0;
   bit          hold_lock = 1'b0;
   int          cyc = 0, rst_fall_cyc = 0;
   bit          prev_busy = 1'b1, prev_mrst = 1'b1;
   acc_t        mon_a;
   out_t        mon_o;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Registered ROM: data reflects the address presented one cycle earlier
   initial begin
      logic [4:0] a_s;
      rom_data = '0;
      forever begin
         @(negedge clk12);
         a_s = rom_addr;
         @(posedge clk12);
         #1 rom_data = rom_mem[a_s];
      end
   end

   // MMCM DRP model: responds after lat wait cycles, skips the access numbered drop_at
   initial begin
      bit we; logic [6:0] ad; logic [15:0] dv; int n, l;
      drp.drp_drdy = 1'b0;
      drp.drp_do   = '0;
      forever begin
         @(negedge clk12);
         drp.drp_drdy = 1'b0;
         if (drp.drp_den === 1'b1) begin
            we = drp.drp_dwe; ad = drp.drp_daddr; dv = drp.drp_di;
            n = acc_n; acc_n++;
            if (n != drop_at) begin
               l = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 6));
               repeat (l + 1) @(negedge clk12);
               if (we) mmcm_mem[ad] = dv;
               else    drp.drp_do   = mmcm_mem[ad];
               drp.drp_drdy = 1'b1;
            end
         end
      end
   end

   // MMCM lock model: locks LOCK_LAT cycles after reset is released
   initial begin
      int cnt;
      cnt = 0;
      drp.mmcm_locked = 1'b0;
      forever begin
         @(posedge clk12);
         #2;
         if (drp.mmcm_rst !== 1'b0) begin
            cnt = 0;
            drp.mmcm_locked = 1'b0;
         end else if (!hold_lock) begin
            if (cnt < LOCK_LAT) cnt++;
            drp.mmcm_locked = (cnt >= LOCK_LAT);
         end
      end
   end

   // Monitor: compare each DRP strobe and each return to idle against the scoreboard
   always @(negedge clk12) begin
      cyc++;
      if (prev_mrst && drp.mmcm_rst === 1'b0) rst_fall_cyc = cyc;
      prev_mrst = (drp.mmcm_rst !== 1'b0);
      if (!rst && drp.drp_den === 1'b1) begin
         if (acc_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_drp_access actual addr=%0h expected none", drp.drp_daddr);
         end else begin
            mon_a = acc_q.pop_front();
            chk("drp_dwe", 32'(drp.drp_dwe), 32'(mon_a.we));
            chk("drp_daddr", 32'(drp.drp_daddr), 32'(mon_a.addr));
            chk("rom_addr", 32'(rom_addr), 32'(mon_a.rom));
            chk("mmcm_rst_held", 32'(drp.mmcm_rst), 32'd1);
            if (mon_a.we) chk("drp_di", 32'(drp.drp_di), 32'(mon_a.di));
         end
      end
      if (!rst && prev_busy && cfg_busy === 1'b0) begin
         if (out_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_completion actual done=%0b err=%0b expected none", cfg_done, cfg_err);
         end else begin
            mon_o = out_q.pop_front();
            chk("cfg_done", 32'(cfg_done), 32'(mon_o.done));
            chk("cfg_err", 32'(cfg_err), 32'(mon_o.err));
            chk("mmcm_rst_idle", 32'(drp.mmcm_rst), 32'd0);
            if (mon_o.lock_to) chk("lock_timeout_cycles", 32'(cyc - rst_fall_cyc), 32'(LOCK_TO));
         end
      end
      prev_busy = (cfg_busy !== 1'b0);
   end

   // Reference model: expected DRP traffic and outcome for one request
   task automatic expect_req(input int sel, input bit lock_fail);
      bit err; logic [38:0] e; logic [15:0] old, nv; acc_t r; out_t o;
      err = 1'b0;
      for (int i = 0; i < 8; i++) begin
         e = rom_mem[sel * 8 + i];
         r.we = 1'b0; r.addr = e[38:32]; r.di = '0; r.rom = 5'(sel * 8 + i);
         acc_q.push_back(r);
         if (2 * i == drop_at || lat_fix >= DRDY_TO) begin
            err = 1'b1;
            break;
         end
         old = ref_mem[e[38:32]];
         for (int b = 0; b < 16; b++) nv[b] = e[16 + b] ? old[b] : e[b];
         ref_mem[e[38:32]] = nv;
         r.we = 1'b1; r.di = nv;
         acc_q.push_back(r);
      end
      o.done = !err && !lock_fail;
      o.err = err || lock_fail;
      o.lock_to = !err && lock_fail;
      out_q.push_back(o);
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (cfg_busy !== 1'b0 && n < budget) begin
         @(negedge clk12);
         n++;
      end
      if (n >= budget) begin
         checks++; errors++;
         $display("FAIL idle_timeout actual busy=%0b expected 0 within %0d cycles", cfg_busy, budget);
      end
   endtask

   task automatic issue(input int sel);
      acc_n = 0;
      @(negedge clk12);
      cfg_sel = 2'(sel);
      cfg_req = 1'b1;
      @(negedge clk12);
      cfg_req = 1'b0;
      cfg_sel = 2'($urandom);
      chk("busy_on_accept", 32'(cfg_busy), 32'd1);
      chk("err_clear_on_accept", 32'(cfg_err), 32'd0);
   endtask

   task automatic do_req(input int sel, input bit lock_fail, input bit poke);
      expect_req(sel, lock_fail);
      hold_lock = lock_fail;
      issue(sel);
      if (poke) begin
         repeat (12) @(negedge clk12);
         cfg_sel = 2'(sel ^ 1);
         cfg_req = 1'b1;
         @(negedge clk12);
         cfg_req = 1'b0;
      end
      wait_idle(20000);
      hold_lock = 1'b0;
      repeat (4) @(negedge clk12);
   endtask

   task automatic reset_checks();
      chk("rst_mmcm_rst", 32'(drp.mmcm_rst), 32'd1);
      chk("rst_busy", 32'(cfg_busy), 32'd1);
      chk("rst_den", 32'(drp.drp_den), 32'd0);
      chk("rst_dwe", 32'(drp.drp_dwe), 32'd0);
      chk("rst_done", 32'(cfg_done), 32'd0);
   endtask

   task automatic boot_from_reset();
      int n;
      out_t o;
      o.done = 1'b0; o.err = 1'b0; o.lock_to = 1'b0;
      out_q.push_back(o);
      rst = 1'b0;
      chk("mmcm_rst_release_cycle", 32'(drp.mmcm_rst), 32'd1);
      @(negedge clk12);
      chk("mmcm_rst_low_after_release", 32'(drp.mmcm_rst), 32'd0);
      n = 0;
      while (drp.mmcm_locked !== 1'b1 && n < 1000) begin
         @(negedge clk12);
         n++;
      end
      if (n >= 1000) begin
         checks++; errors++;
         $display("FAIL lock_model_timeout actual locked=%0b expected 1", drp.mmcm_locked);
      end
      n = 0;
      while (cfg_busy !== 1'b0 && n < 20) begin
         @(negedge clk12);
         n++;
      end
      chk("busy_fall_after_lock", 32'(n), 32'd3);
      repeat (4) @(negedge clk12);
   endtask

   initial begin
      int n, sel;
      int lats[4] = '{1, 5, 63, 64};
      rst = 1'b1; cfg_req = 1'b0; cfg_sel = '0;
      for (int i = 0; i < 32; i++) rom_mem[i] = {7'($urandom), $urandom};
      for (int i = 16; i < 24; i++) rom_mem[i] = {7'h08, 16'h1000, 16'h0145};
      for (int i = 0; i < 128; i++) mmcm_mem[i] = 16'($urandom);
      mmcm_mem[8] = 16'hFFFF;
      for (int i = 0; i < 128; i++) ref_mem[i] = mmcm_mem[i];

      repeat (3) @(negedge clk12);
      reset_checks();
      chk("rst_err", 32'(cfg_err), 32'd0);
      chk("rst_rom_addr", 32'(rom_addr), 32'd0);
      chk("rst_daddr", 32'(drp.drp_daddr), 32'd0);
      chk("rst_di", 32'(drp.drp_di), 32'd0);
      boot_from_reset();

      // Directed config 2 with a busy-time request that must be ignored
      do_req(2, 1'b0, 1'b1);
      chk("single_result_value", 32'(mmcm_mem[8]), 32'h1145);
      chk("single_access_count", 32'(acc_n), 32'd16);

      // Random configurations with random DRDY latency
      for (int k = 0; k < 6; k++) do_req(int'($urandom_range(0, 3)), 1'b0, k[0]);

      // Third read never acknowledged
      drop_at = 4;
      do_req(int'($urandom_range(0, 3)), 1'b0, 1'b0);
      chk("timeout_access_count", 32'(acc_n), 32'd5);
      drop_at = -1;
      do_req(int'($urandom_range(0, 3)), 1'b0, 1'b0);

      // DRDY latency sweep; 64 wait cycles without DRDY exceeds the budget
      foreach (lats[j]) begin
         lat_fix = lats[j];
         do_req(int'($urandom_range(0, 3)), 1'b0, 1'b0);
      end
      lat_fix = -1;
      repeat (80) @(negedge clk12);

      // Lock never arrives
      do_req(int'($urandom_range(0, 3)), 1'b1, 1'b0);
      do_req(int'($urandom_range(0, 3)), 1'b0, 1'b0);

      // Reset in the middle of entry 4
      sel = int'($urandom_range(0, 3));
      expect_req(sel, 1'b0);
      issue(sel);
      n = 0;
      while (acc_n < 9 && n < 2000) begin
         @(negedge clk12);
         n++;
      end
      if (n >= 2000) begin
         checks++; errors++;
         $display("FAIL midop_wait actual accesses=%0d expected 9", acc_n);
      end
      rst = 1'b1;
      @(negedge clk12);
      acc_q.delete();
      out_q.delete();
      chk("midop_den_low", 32'(drp.drp_den), 32'd0);
      repeat (2) @(negedge clk12);
      reset_checks();
      boot_from_reset();
      for (int i = 0; i < 128; i++) ref_mem[i] = mmcm_mem[i];
      do_req(int'($urandom_range(0, 3)), 1'b0, 1'b0);

      chk("acc_queue_drained", 32'(acc_q.size()), 32'd0);
      chk("out_queue_drained", 32'(out_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog");
   end
endmodule
